// File: rtl/smooth_job_scheduler.sv
// smooth_job_scheduler
// Round-robin scheduler that shares one smoothing/MAC datapath between two
// sample channels. It grants a requesting channel, latches that channel's
// mode bits and buffer address, and pulses ready to the smoothing controller.
// It then waits for out_en, acks the requester and advances that channel's
// sample index. A watchdog abandons jobs whose out_en never arrives.
//
// Ports
//   sys_clk, reset      : clock; synchronous active-high reset
//   req[1:0]            : per-channel request level, held until ack
//   smooth_cfg[1:0]     : per-channel smoothing enable
//   bypass_cfg[1:0]     : per-channel stage1 bypass
//   out_en              : job-complete pulse from the smoothing controller
//   ready               : one-cycle job start
//   stage1, smooth      : latched mode bits of the granted channel
//   base_addr           : grant_ch*FRAME_LEN + idx[grant_ch]
//   grant_ch            : channel being served
//   busy                : high whenever the scheduler is not idle
//   ack[1:0]            : one-cycle per-channel completion pulse
//   frame_done[1:0]     : one-cycle pulse when a channel's index wraps
//   timeout_err         : sticky watchdog flag
module smooth_job_scheduler #(
  parameter int ADDR_W    = 8,
  parameter int FRAME_LEN = 16,
  parameter int TIMEOUT   = 15
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        smooth_cfg,
  input  logic [1:0]        bypass_cfg,
  input  logic              out_en,
  output logic              ready,
  output logic              stage1,
  output logic              smooth,
  output logic [ADDR_W-1:0] base_addr,
  output logic              grant_ch,
  output logic              busy,
  output logic [1:0]        ack,
  output logic [1:0]        frame_done,
  output logic              timeout_err
);

  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic                     last_ch_q, last_ch_d;
  logic [1:0][IDX_W-1:0]    idx_q, idx_d;
  logic [TMR_W-1:0]         timer_q, timer_d;
  logic                     ready_q, ready_d;
  logic                     stage1_q, stage1_d;
  logic                     smooth_q, smooth_d;
  logic [ADDR_W-1:0]        base_addr_q, base_addr_d;
  logic                     grant_ch_q, grant_ch_d;
  logic                     busy_q, busy_d;
  logic [1:0]               ack_q, ack_d;
  logic [1:0]               frame_done_q, frame_done_d;
  logic                     timeout_err_q, timeout_err_d;
  logic                     pick_s;
  logic [TMR_W-1:0]         timer_inc_s;

  // Buffer base address of a channel's current sample slot.
  function automatic logic [ADDR_W-1:0] addr_of(input logic ch, input logic [IDX_W-1:0] idx);
    addr_of = (ch ? ADDR_W'(FRAME_LEN) : {ADDR_W{1'b0}}) + ADDR_W'(idx);
  endfunction

  assign timer_inc_s = timer_q + {{(TMR_W-1){1'b0}}, 1'b1};

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    last_ch_d     = last_ch_q;
    idx_d         = idx_q;
    timer_d       = timer_q;
    stage1_d      = stage1_q;
    smooth_d      = smooth_q;
    base_addr_d   = base_addr_q;
    grant_ch_d    = grant_ch_q;
    timeout_err_d = timeout_err_q;
    ready_d       = 1'b0;
    ack_d         = 2'b00;
    frame_done_d  = 2'b00;
    pick_s        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          // A tie goes to the channel that was not served last.
          if (req == 2'b11) begin
            pick_s = ~last_ch_q;
          end else begin
            pick_s = req[1];
          end
          // Mode bits and address are captured here so they are valid
          // from the GRANT cycle through DONE.
          grant_ch_d  = pick_s;
          stage1_d    = bypass_cfg[pick_s];
          smooth_d    = smooth_cfg[pick_s];
          base_addr_d = addr_of(pick_s, idx_q[pick_s]);
          state_d     = S_GRANT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        ready_d = 1'b1;
        state_d = S_START;
      end
      S_START: begin
        timer_d = {TMR_W{1'b0}};
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_inc_s;
        if (out_en) begin
          ack_d[grant_ch_q] = 1'b1;
          if (idx_q[grant_ch_q] == IDX_W'(FRAME_LEN - 1)) begin
            idx_d[grant_ch_q]        = {IDX_W{1'b0}};
            frame_done_d[grant_ch_q] = 1'b1;
          end else begin
            idx_d[grant_ch_q] = idx_q[grant_ch_q] + {{(IDX_W-1){1'b0}}, 1'b1};
          end
          state_d = S_DONE;
        end else if (timer_inc_s == TMR_W'(TIMEOUT)) begin
          // Abandon the job: ack the requester but leave its index alone.
          timeout_err_d     = 1'b1;
          ack_d[grant_ch_q] = 1'b1;
          state_d           = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        last_ch_d = grant_ch_q;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      last_ch_q     <= 1'b1;
      idx_q         <= '0;
      timer_q       <= {TMR_W{1'b0}};
      ready_q       <= 1'b0;
      stage1_q      <= 1'b0;
      smooth_q      <= 1'b0;
      base_addr_q   <= {ADDR_W{1'b0}};
      grant_ch_q    <= 1'b0;
      busy_q        <= 1'b0;
      ack_q         <= 2'b00;
      frame_done_q  <= 2'b00;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_ch_q     <= last_ch_d;
      idx_q         <= idx_d;
      timer_q       <= timer_d;
      ready_q       <= ready_d;
      stage1_q      <= stage1_d;
      smooth_q      <= smooth_d;
      base_addr_q   <= base_addr_d;
      grant_ch_q    <= grant_ch_d;
      busy_q        <= busy_d;
      ack_q         <= ack_d;
      frame_done_q  <= frame_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign ready       = ready_q;
  assign stage1      = stage1_q;
  assign smooth      = smooth_q;
  assign base_addr   = base_addr_q;
  assign grant_ch    = grant_ch_q;
  assign busy        = busy_q;
  assign ack         = ack_q;
  assign frame_done  = frame_done_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_smooth_job_scheduler.sv
// Self-checking bench for smooth_job_scheduler. Stimulus and sampling happen
// on the falling clock edge; the reference model tracks per-channel indices,
// the last-served channel and the sticky error flag as plain integers.
module tb_smooth_job_scheduler;
  localparam int AW = 8;
  localparam int FL = 16;
  localparam int TO = 15;

  logic          sys_clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    req = 2'b00;
  logic [1:0]    smooth_cfg = 2'b00;
  logic [1:0]    bypass_cfg = 2'b00;
  logic          out_en = 1'b0;
  logic          ready, stage1, smooth, grant_ch, busy, timeout_err;
  logic [AW-1:0] base_addr;
  logic [1:0]    ack, frame_done;

  int checks = 0;
  int errors = 0;
  int idx_m [2];
  int last_m;
  bit err_m;

  always #5 sys_clk = ~sys_clk;

  smooth_job_scheduler #(.ADDR_W(AW), .FRAME_LEN(FL), .TIMEOUT(TO)) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .req        (req),
    .smooth_cfg (smooth_cfg),
    .bypass_cfg (bypass_cfg),
    .out_en     (out_en),
    .ready      (ready),
    .stage1     (stage1),
    .smooth     (smooth),
    .base_addr  (base_addr),
    .grant_ch   (grant_ch),
    .busy       (busy),
    .ack        (ack),
    .frame_done (frame_done),
    .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    idx_m[0] = 0;
    idx_m[1] = 0;
    last_m   = 1;
    err_m    = 1'b0;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    req    = 2'b00;
    out_en = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_base_addr", 32'(base_addr), 32'd0);
    chk("rst_grant_ch", 32'(grant_ch), 32'd0);
    chk("rst_stage1", 32'(stage1), 32'd0);
    chk("rst_smooth", 32'(smooth), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    reset = 1'b0;
    model_reset();
  endtask

  // One job starting from IDLE at a falling edge. dly = WAIT cycle in which
  // out_en is raised (0 = never). glitch raises out_en in IDLE and GRANT.
  // rst_at = WAIT cycle in which reset is applied (0 = none).
  task automatic do_job(input logic [1:0] rq, input int dly, input bit glitch, input int rst_at);
    int g, nw, exp_base;
    bit ok, sm, bp, wrap;
    logic [1:0] ack_e, fd_e;
    g = (rq == 2'b11) ? (1 - last_m) : ((rq == 2'b10) ? 1 : 0);
    sm = smooth_cfg[g];
    bp = bypass_cfg[g];
    exp_base = g * FL + idx_m[g];
    ok = (dly >= 1) && (dly <= TO);
    nw = ok ? dly : TO;
    req    = rq;
    out_en = glitch;
    @(negedge sys_clk);  // GRANT
    chk("grant_busy", 32'(busy), 32'd1);
    chk("grant_ch", 32'(grant_ch), 32'(g));
    chk("grant_base_addr", 32'(base_addr), 32'(exp_base));
    chk("grant_smooth", 32'(smooth), 32'(sm));
    chk("grant_stage1", 32'(stage1), 32'(bp));
    chk("grant_ready", 32'(ready), 32'd0);
    chk("grant_ack", 32'(ack), 32'd0);
    smooth_cfg = 2'($urandom);
    bypass_cfg = 2'($urandom);
    @(negedge sys_clk);  // START
    chk("start_ready", 32'(ready), 32'd1);
    chk("start_ack", 32'(ack), 32'd0);
    chk("start_base_addr", 32'(base_addr), 32'(exp_base));
    out_en = 1'b0;
    for (int w = 1; w <= nw; w++) begin
      @(negedge sys_clk);  // WAIT cycle w
      chk("wait_ready", 32'(ready), 32'd0);
      chk("wait_ack", 32'(ack), 32'd0);
      chk("wait_busy", 32'(busy), 32'd1);
      chk("wait_smooth", 32'(smooth), 32'(sm));
      chk("wait_stage1", 32'(stage1), 32'(bp));
      chk("wait_timeout_err", 32'(timeout_err), 32'(err_m));
      if (w == rst_at) begin
        reset  = 1'b1;
        req    = 2'b00;
        out_en = 1'b0;
        @(negedge sys_clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ack", 32'(ack), 32'd0);
        chk("midrst_ready", 32'(ready), 32'd0);
        chk("midrst_timeout_err", 32'(timeout_err), 32'd0);
        chk("midrst_base_addr", 32'(base_addr), 32'd0);
        reset = 1'b0;
        model_reset();
        return;
      end
      out_en     = (w == dly);
      smooth_cfg = 2'($urandom);
    end
    @(negedge sys_clk);  // DONE
    wrap  = ok && (idx_m[g] == FL - 1);
    ack_e = 2'(1 << g);
    fd_e  = wrap ? ack_e : 2'b00;
    chk("done_ack", 32'(ack), 32'(ack_e));
    chk("done_frame_done", 32'(frame_done), 32'(fd_e));
    chk("done_timeout_err", 32'(timeout_err), 32'(err_m | !ok));
    chk("done_busy", 32'(busy), 32'd1);
    chk("done_smooth", 32'(smooth), 32'(sm));
    chk("done_ready", 32'(ready), 32'd0);
    out_en = 1'b0;
    req    = 2'b00;
    if (ok) begin
      idx_m[g] = (idx_m[g] + 1) % FL;
    end else begin
      err_m = 1'b1;
    end
    last_m = g;
    @(negedge sys_clk);  // IDLE
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_ack", 32'(ack), 32'd0);
    chk("idle_frame_done", 32'(frame_done), 32'd0);
    chk("idle_ready", 32'(ready), 32'd0);
  endtask

  initial begin
    model_reset();
    do_reset();

    // Single channel-0 job, out_en four cycles after ready.
    smooth_cfg = 2'b01;
    bypass_cfg = 2'b00;
    do_job(2'b01, 4, 1'b0, 0);
    do_job(2'b01, 2, 1'b0, 0);

    // Both channels requesting: strict alternation from a fresh reset.
    do_reset();
    repeat (4) do_job(2'b11, 2, 1'b0, 0);

    // Channel 1 served a full frame, then once more after the wrap.
    do_reset();
    repeat (16) do_job(2'b10, $urandom_range(1, 4), 1'b0, 0);
    do_job(2'b10, 2, 1'b0, 0);

    // Watchdog: no out_en, then normal jobs with the flag held.
    do_job(2'b01, 0, 1'b0, 0);
    do_job(2'b10, 3, 1'b0, 0);
    do_job(2'b01, 1, 1'b0, 0);

    // out_en outside WAIT is ignored.
    out_en = 1'b1;
    @(negedge sys_clk);
    chk("idle_glitch_busy", 32'(busy), 32'd0);
    chk("idle_glitch_ack", 32'(ack), 32'd0);
    out_en = 1'b0;
    do_job(2'b01, 2, 1'b1, 0);

    // Reset during WAIT, then a job from the cleared state.
    do_job(2'b11, 3, 1'b0, 2);
    do_job(2'b01, 2, 1'b0, 0);

    // Randomised traffic including occasional timeouts and glitches.
    for (int n = 0; n < 40; n++) begin
      smooth_cfg = 2'($urandom);
      bypass_cfg = 2'($urandom);
      do_job(2'($urandom_range(1, 3)), $urandom_range(0, 6), 1'($urandom), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
